// File: rtl/odpc_pkg.sv
// Shared constants and helpers for the ODPC word serializer.
//   CH_X/CH_LBP1/CH_LBP2 : channel lane indices inside the packed word set
//   DEF_*                : default geometry (3 channels, 16-bit words, 8-bit beats)
//   beats()              : number of narrow beats per wide word
//   beat_w()             : width of a beat index, never less than one bit
package odpc_pkg;

  localparam int CH_X    = 0;
  localparam int CH_LBP1 = 1;
  localparam int CH_LBP2 = 2;

  localparam int DEF_NCH   = 3;
  localparam int DEF_IN_W  = 16;
  localparam int DEF_OUT_W = 8;

  function automatic int beats(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  function automatic int beat_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/odpc_word_buf.sv
// One-entry holding buffer for a complete word set.
//   clk, reset  : rising-edge clock, asynchronous active-low reset
//   flush       : synchronous drop of the held entry, beats load/unload
//   load        : capture load_data and mark full
//   unload      : mark empty (contents are taken by the consumer the same edge)
//   data, full  : held word set and occupancy flag
module odpc_word_buf
  import odpc_pkg::*;
#(
  parameter int W = DEF_NCH * DEF_IN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] load_data,
  output logic [W-1:0] data,
  output logic         full
);

  logic [W-1:0] data_reg;
  logic         full_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_reg <= '0;
      full_reg <= 1'b0;
    end else begin
      // load and unload never coincide: load needs an empty buffer, unload a full one
      if (flush)       full_reg <= 1'b0;
      else if (load)   full_reg <= 1'b1;
      else if (unload) full_reg <= 1'b0;
      if (load && !flush) data_reg <= load_data;
    end
  end

  assign data = data_reg;
  assign full = full_reg;

endmodule

// File: rtl/lbp_word_serializer.sv
// Splits one wide word per channel (x, lbp1, lbp2, replicas) into BEATS narrow beats
// on a valid/ready stream. A one-entry buffer behind the active shift register lets a
// new word set be accepted while the current one is still being emitted, giving one
// beat per cycle in steady state.
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   flush               : synchronous drop of active and buffered words
//   in_valid/in_ready   : input word-set handshake, in_data channel c at [c*IN_W +: IN_W]
//   out_valid/out_ready : output beat handshake, out_data channel c at [c*OUT_W +: OUT_W]
//   out_beat            : beat index shared by all channels
//   out_first/out_last  : out_beat is 0 / BEATS-1
module lbp_word_serializer
  import odpc_pkg::*;
#(
  parameter  int NCH       = DEF_NCH,
  parameter  int IN_W      = DEF_IN_W,
  parameter  int OUT_W     = DEF_OUT_W,
  parameter  bit MSB_FIRST = 1'b1,
  localparam int BEATS     = beats(IN_W, OUT_W),
  localparam int BEAT_W    = beat_w(BEATS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH*IN_W-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NCH*OUT_W-1:0]  out_data,
  output logic [BEAT_W-1:0]     out_beat,
  output logic                  out_first,
  output logic                  out_last
);

  if ((IN_W % OUT_W) != 0 || (IN_W / OUT_W) < 2) begin : g_bad_geometry
    $error("lbp_word_serializer: IN_W must be a multiple of OUT_W with at least two beats");
  end

  logic [NCH*IN_W-1:0] shift_reg;
  logic [NCH*IN_W-1:0] shift_next;
  logic [NCH*IN_W-1:0] buf_data;
  logic [BEAT_W-1:0]   cnt_reg;
  logic                act_valid_reg;
  logic                buf_full;

  logic in_fire;
  logic out_fire;
  logic act_last;
  logic act_free;
  logic buf_load;
  logic buf_unload;

  assign in_ready   = !buf_full;
  assign in_fire    = in_valid && in_ready;
  assign out_valid  = act_valid_reg;
  assign out_fire   = act_valid_reg && out_ready;
  assign act_last   = (cnt_reg == BEAT_W'(BEATS - 1));
  // Active slot can take a new word this edge if idle or emitting its final beat
  assign act_free   = !act_valid_reg || (out_fire && act_last);
  assign buf_load   = in_fire && !act_free;
  assign buf_unload = act_free && buf_full;

  assign out_beat  = cnt_reg;
  assign out_first = (cnt_reg == '0);
  assign out_last  = act_last;

  // Per-channel beat extraction and shift toward the beat0 position
  for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
    logic [IN_W-1:0] word;
    assign word = shift_reg[gi*IN_W +: IN_W];
    if (MSB_FIRST) begin : g_msb
      assign out_data[gi*OUT_W +: OUT_W]  = word[IN_W-1 -: OUT_W];
      assign shift_next[gi*IN_W +: IN_W] = word << OUT_W;
    end else begin : g_lsb
      assign out_data[gi*OUT_W +: OUT_W]  = word[OUT_W-1:0];
      assign shift_next[gi*IN_W +: IN_W] = word >> OUT_W;
    end
  end

  odpc_word_buf #(
    .W (NCH * IN_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .load      (buf_load),
    .unload    (buf_unload),
    .load_data (in_data),
    .data      (buf_data),
    .full      (buf_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_valid_reg <= 1'b0;
      cnt_reg       <= '0;
      shift_reg     <= '0;
    end else if (flush) begin
      act_valid_reg <= 1'b0;
      cnt_reg       <= '0;
    end else if (act_free) begin
      if (buf_full) begin
        shift_reg     <= buf_data;
        cnt_reg       <= '0;
        act_valid_reg <= 1'b1;
      end else if (in_fire) begin
        shift_reg     <= in_data;
        cnt_reg       <= '0;
        act_valid_reg <= 1'b1;
      end else begin
        // Counter parks at BEATS-1 until the next load; out_valid masks it
        act_valid_reg <= 1'b0;
      end
    end else if (out_fire) begin
      cnt_reg   <= cnt_reg + BEAT_W'(1);
      shift_reg <= shift_next;
    end
  end

endmodule

// File: tb/tb_lbp_word_serializer.sv
module tb_lbp_word_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, out_ready;
  logic        in_valid, in_ready, out_valid, out_first, out_last;
  logic [47:0] in_data;
  logic [23:0] out_data;
  logic [0:0]  out_beat;

  logic        in_valid6;
  logic [63:0] in_data6;
  logic        in_ready_m, out_valid_m, out_first_m, out_last_m;
  logic        in_ready_l, out_valid_l, out_first_l, out_last_l;
  logic [15:0] out_data_m, out_data_l;
  logic [1:0]  out_beat_m, out_beat_l;

  lbp_word_serializer dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_beat(out_beat), .out_first(out_first), .out_last(out_last)
  );

  lbp_word_serializer #(.NCH(2), .IN_W(32), .OUT_W(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid6), .in_ready(in_ready_m), .in_data(in_data6),
    .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m),
    .out_beat(out_beat_m), .out_first(out_first_m), .out_last(out_last_m)
  );

  lbp_word_serializer #(.NCH(2), .IN_W(32), .OUT_W(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid6), .in_ready(in_ready_l), .in_data(in_data6),
    .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l),
    .out_beat(out_beat_l), .out_first(out_first_l), .out_last(out_last_l)
  );

  typedef struct {
    logic [23:0] data;
    logic [1:0]  beat;
    logic        first;
    logic        last;
  } exp_t;

  exp_t q0[$];
  exp_t qm[$];
  exp_t ql[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic exp_t mk(input logic [23:0] d, input logic [1:0] b,
                              input logic f, input logic l);
    exp_t e;
    e.data = d; e.beat = b; e.first = f; e.last = l;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops one expected beat per output handshake, independent of stimulus
  always @(negedge clk) begin
    exp_t e;
    if (!reset || flush) begin
      q0.delete(); qm.delete(); ql.delete();
    end else if (out_ready) begin
      if (out_valid) begin
        if (q0.size() == 0) check("beat_unexpected", {out_data, 1'b0, out_beat}, 64'hDEAD);
        else begin
          e = q0.pop_front();
          check("beat", {out_data, 1'b0, out_beat, out_first, out_last},
                {e.data, e.beat, e.first, e.last});
          $display("beat  data=%h beat=%0d first=%b last=%b", out_data, out_beat, out_first, out_last);
        end
      end
      if (out_valid_m) begin
        if (qm.size() == 0) check("beat_m_unexpected", {out_data_m, out_beat_m}, 64'hDEAD);
        else begin
          e = qm.pop_front();
          check("beat_m", {8'h00, out_data_m, out_beat_m, out_first_m, out_last_m},
                {e.data, e.beat, e.first, e.last});
          $display("beat_m data=%h beat=%0d last=%b", out_data_m, out_beat_m, out_last_m);
        end
      end
      if (out_valid_l) begin
        if (ql.size() == 0) check("beat_l_unexpected", {out_data_l, out_beat_l}, 64'hDEAD);
        else begin
          e = ql.pop_front();
          check("beat_l", {8'h00, out_data_l, out_beat_l, out_first_l, out_last_l},
                {e.data, e.beat, e.first, e.last});
          $display("beat_l data=%h beat=%0d last=%b", out_data_l, out_beat_l, out_last_l);
        end
      end
    end
  end

  // Present a word set; expected beats are queued when the handshake is seen.
  // Returns on the negedge before the accepting edge.
  task automatic send0(input logic [47:0] d, input logic [23:0] b0, input logic [23:0] b1);
    int k;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk); #1;
    end
    check("send_accept", {63'd0, k < 50}, 64'd1);
    if (k < 50) begin
      q0.push_back(mk(b0, 2'd0, 1'b1, 1'b0));
      q0.push_back(mk(b1, 2'd1, 1'b0, 1'b1));
      $display("send  data=%h", d);
    end
  endtask

  task automatic idle0();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (q0.size() == 0 && qm.size() == 0 && ql.size() == 0) break;
    end
    check(name, {63'd0, k < 100}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_data = '0; in_valid6 = 1'b0; in_data6 = '0;

    // Reset state
    #2 reset = 1'b0;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data",  {40'd0, out_data}, 64'd0);
    check("rst_flags", {60'd0, out_beat, out_first, out_last, in_ready}, {60'd0, 4'b0101});
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;

    // T2: single word, one cycle latency, two beats
    send0(48'hE5F6_C3D4_A1B2, 24'hE5C3A1, 24'hF6D4B2);
    idle0();
    @(negedge clk);
    check("t2_first", {62'd0, out_valid, out_first}, 64'b11);
    @(negedge clk);
    check("t2_last", {62'd0, out_valid, out_last}, 64'b11);
    @(negedge clk);
    check("t2_idle", {63'd0, out_valid}, 64'd0);
    wait_drain("t2_drain");

    // T3: four words back to back, no bubbles, in_ready alternates
    fork
      begin
        send0(48'h0102_0304_0506, 24'h010305, 24'h020406);
        send0(48'h1112_1314_1516, 24'h111315, 24'h121416);
        send0(48'h2122_2324_2526, 24'h212325, 24'h222426);
        send0(48'h3132_3334_3536, 24'h313335, 24'h323436);
        idle0();
      end
      begin
        int k;
        for (k = 0; k < 30; k++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        check("t3_start", {63'd0, k < 30}, 64'd1);
        for (int i = 0; i < 8; i++) begin
          if (i > 0) @(negedge clk);
          check("t3_nogap", {63'd0, out_valid}, 64'd1);
          check("t3_in_ready", {63'd0, in_ready}, (i < 6) ? 64'(i % 2 == 0) : 64'd1);
        end
      end
    join
    wait_drain("t3_drain");

    // T4: backpressure at beat1 while more words arrive
    out_ready = 1'b1;
    send0(48'h3C4D_5E6F_7A8B, 24'h3C5E7A, 24'h4D6F8B);
    fork
      begin
        send0(48'h9091_9293_9495, 24'h909294, 24'h919395);
        send0(48'hA0A1_A2A3_A4A5, 24'hA0A2A4, 24'hA1A3A5);
        idle0();
      end
      begin
        int k;
        for (k = 0; k < 20; k++) begin
          @(posedge clk); #1;
          if (out_valid && out_beat == 1'b1) break;
        end
        check("t4_reach_beat1", {63'd0, k < 20}, 64'd1);
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("t4_frozen", {39'd0, out_valid, out_data}, {39'd0, 1'b1, 24'h4D6F8B});
          check("t4_beat", {63'd0, out_beat}, 64'd1);
        end
        check("t4_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_drain("t4_drain");

    // T5: flush with active and buffer occupied
    out_ready = 1'b0;
    send0(48'hDEAD_BEEF_CAFE, 24'hDEBECA, 24'hADEFFE);
    send0(48'h5566_7788_99AA, 24'h557799, 24'h6688AA);
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("t5_pre_full", {62'd0, out_valid, in_ready}, 64'b10);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("t5_post", {62'd0, out_valid, in_ready}, 64'b01);
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("t5_no_beat", {63'd0, out_valid}, 64'd0);
    end

    // T1: reset mid-word at beat1
    send0(48'h0F1E_2D3C_4B5A, 24'h0F2D4B, 24'h1E3C5A);
    idle0();
    @(posedge clk); #1;
    check("t1_at_beat1", {62'd0, out_valid, out_beat}, 64'b11);
    reset = 1'b0;
    #1;
    check("t1_rst_valid_data", {39'd0, out_valid, out_data}, 64'd0);
    check("t1_rst_flags", {60'd0, out_beat, out_first, out_last, in_ready}, {60'd0, 4'b0101});
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("t1_no_beat", {63'd0, out_valid}, 64'd0);
    end

    // T6: 32-bit words in 8-bit beats, both beat orders
    @(posedge clk); #1;
    in_valid6 = 1'b1;
    in_data6  = {32'hAABBCCDD, 32'h11223344};
    @(negedge clk);
    check("t6_ready", {62'd0, in_ready_m, in_ready_l}, 64'b11);
    qm.push_back(mk(24'hAA11, 2'd0, 1'b1, 1'b0));
    qm.push_back(mk(24'hBB22, 2'd1, 1'b0, 1'b0));
    qm.push_back(mk(24'hCC33, 2'd2, 1'b0, 1'b0));
    qm.push_back(mk(24'hDD44, 2'd3, 1'b0, 1'b1));
    ql.push_back(mk(24'hDD44, 2'd0, 1'b1, 1'b0));
    ql.push_back(mk(24'hCC33, 2'd1, 1'b0, 1'b0));
    ql.push_back(mk(24'hBB22, 2'd2, 1'b0, 1'b0));
    ql.push_back(mk(24'hAA11, 2'd3, 1'b0, 1'b1));
    $display("send6 data=%h", in_data6);
    @(posedge clk); #1 in_valid6 = 1'b0;
    wait_drain("t6_drain");
    @(negedge clk);
    check("t6_idle", {62'd0, out_valid_m, out_valid_l}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
